// File: rtl/stride_seq_pkg.sv
// Shared mode and direction encodings for the stride sequence counter.
package stride_seq_pkg;
    localparam logic [1:0] MODE_WRAP   = 2'd0;
    localparam logic [1:0] MODE_HOLD   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/stride_next_calc.sv
// Next-state function of the stride sequence: step, terminal detect, wrap/hold/bounce.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to commit the result.
module stride_next_calc
    import stride_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  logic             done,
    input  logic [WIDTH-1:0] start,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count_nxt,
    output logic             dir_nxt,
    output logic             done_nxt,
    output logic             term
);
    // One extra bit so the sum can never alias back below the limit.
    logic [WIDTH:0]   up;
    logic [WIDTH:0]   down_floor;
    logic [WIDTH-1:0] down;

    always_comb begin
        up         = {1'b0, count} + {1'b0, step};
        down_floor = {1'b0, start} + {1'b0, step};
        down       = count - step;
        count_nxt  = count;
        dir_nxt    = dir;
        done_nxt   = done;
        term       = 1'b0;

        // A zero stride is never allowed to raise a terminal event.
        if (done || step == '0) begin
            term = 1'b0;
        end else if (dir == DIR_UP) begin
            if (up <= {1'b0, limit}) begin
                count_nxt = up[WIDTH-1:0];
            end else begin
                term = 1'b1;
                case (mode)
                    MODE_HOLD:   done_nxt  = 1'b1;
                    MODE_BOUNCE: dir_nxt   = DIR_DOWN;
                    default:     count_nxt = start;
                endcase
            end
        end else begin
            if ({1'b0, count} >= down_floor) begin
                count_nxt = down;
            end else begin
                term    = 1'b1;
                dir_nxt = DIR_UP;
            end
        end
    end
endmodule

// File: rtl/stride_sequence_counter.sv
// Runtime-programmable arithmetic-sequence counter with wrap/hold/bounce and terminal-count pulse.
// Latency: count/dir/done/tc update on the edge that samples en or cfg_load.
// Backpressure: none; en low simply freezes the sequence and clears tc.
module stride_sequence_counter
    import stride_seq_pkg::*;
#(
    parameter int         WIDTH     = 4,
    parameter int         DEF_START = 0,
    parameter int         DEF_STEP  = 3,
    parameter int         DEF_LIMIT = 14,
    parameter logic [1:0] DEF_MODE  = 2'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_step,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic [1:0]       cfg_mode,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             done,
    output logic             tc
);
    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] limit;
    logic [1:0]       mode;

    logic [WIDTH-1:0] count_nxt;
    logic             dir_nxt;
    logic             done_nxt;
    logic             term;

    stride_next_calc #(
        .WIDTH (WIDTH)
    ) u_next (
        .count     (count),
        .dir       (dir),
        .done      (done),
        .start     (start),
        .step      (step),
        .limit     (limit),
        .mode      (mode),
        .count_nxt (count_nxt),
        .dir_nxt   (dir_nxt),
        .done_nxt  (done_nxt),
        .term      (term)
    );

    // cfg_load outranks en so a reload always restarts cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start <= WIDTH'(DEF_START);
            step  <= WIDTH'(DEF_STEP);
            limit <= WIDTH'(DEF_LIMIT);
            mode  <= DEF_MODE;
            count <= WIDTH'(DEF_START);
            dir   <= DIR_UP;
            done  <= 1'b0;
            tc    <= 1'b0;
        end else if (cfg_load) begin
            start <= cfg_start;
            step  <= cfg_step;
            limit <= cfg_limit;
            mode  <= cfg_mode;
            count <= cfg_start;
            dir   <= DIR_UP;
            done  <= 1'b0;
            tc    <= 1'b0;
        end else if (en) begin
            count <= count_nxt;
            dir   <= dir_nxt;
            done  <= done_nxt;
            tc    <= term;
        end else begin
            tc <= 1'b0;
        end
    end
endmodule

// File: doc/stride_sequence_counter.md
# stride_sequence_counter

Parametrised, runtime-programmable arithmetic-sequence counter; successor to the fixed-sequence counters in this codebase. Counts from a programmable start value toward a programmable limit in programmable strides, with wrap, hold or bounce behaviour at the limit. Sits as a timing/sequence generator beside control FSMs that need a non-unit-step index with a terminal-count strobe.

## Interface
- WIDTH, 4: bit width of count and all configuration values
- DEF_START, 0: active start value after reset
- DEF_STEP, 3: active step after reset
- DEF_LIMIT, 14: active limit after reset
- DEF_MODE, 2'd0: active mode after reset (WRAP)

- clk  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-high reset
- en  in  1  advance enable; one step per cycle while high
- cfg_load  in  1  latch cfg_* into active config and restart sequence
- cfg_start  in  WIDTH  start value
- cfg_step  in  WIDTH  stride
- cfg_limit  in  WIDTH  upper bound (inclusive)
- cfg_mode  in  2  0 WRAP, 1 HOLD, 2 BOUNCE, 3 reserved (behaves as WRAP)
- count  out  WIDTH  current sequence value (registered)
- dir  out  1  0 counting up, 1 counting down (BOUNCE only)
- done  out  1  HOLD mode: limit reached, counting stopped
- tc  out  1  one-cycle terminal-count pulse (registered)

## Operation
- Reset: active config = DEF_*; count = DEF_START, dir = 0, done = 0, tc = 0.
- Priority per edge: reset > cfg_load > en > idle.
- cfg_load: active config <= cfg_*; count <= cfg_start; dir <= 0; done <= 0; tc <= 0. en ignored that cycle.
- en low: all state holds, tc <= 0.
- Arithmetic in WIDTH+1 bits, unsigned: up = count + step; down = count - step, underflow tested as count < start + step (WIDTH+1 bits).
- Up step (dir 0, done 0): if up <= limit, count <= up, tc <= 0. Else terminal event, tc <= 1, and per mode:
  - WRAP: count <= start.
  - HOLD: count holds; done <= 1. While done, en has no effect and tc stays 0 (tc pulses once).
  - BOUNCE: count holds; dir <= 1.
- Down step (BOUNCE, dir 1): if count >= start + step, count <= down, tc <= 0. Else count holds, dir <= 0, tc <= 1.
- step = 0: count never moves, tc never asserts (no terminal event).
- start > limit: first enabled cycle is a terminal event (WRAP reloads start each cycle, tc high every enabled cycle).
- Count never exceeds limit except when start > limit; never wraps modulo 2^WIDTH.

## Timing
- All outputs registered; count/dir/done/tc change on the edge that samples en or cfg_load.
- Latency: en high at edge N -> new count visible after edge N; tc high for exactly the cycle after the terminal edge, coinciding with the reloaded/held count.
- Back-to-back en: one step per cycle, no bubbles, including across wrap.
- cfg_load during tc cycle: load wins, tc <= 0 on that edge.
- reset mid-sequence: immediate return to DEF_* state, asynchronous to clk.

## Structure
- Package stride_seq_pkg: mode constants MODE_WRAP, MODE_HOLD, MODE_BOUNCE, MODE_RSVD (2-bit), DIR_UP/DIR_DOWN.
- One sub-module natural: stride_next_calc (combinational) computing next count, next dir, next done and terminal flag from count, dir, done and active config; top holds config and output registers.

## Test plan
- Reset, defaults, en held high -> count 0,3,6,9,12,0,3; tc high only in the cycle count returns to 0.
- cfg_load start 2, step 3, limit 14, mode WRAP -> 2,5,8,11,14,2; tc with second 2.
- Mode HOLD, start 0, step 5, limit 12 -> 0,5,10,10,10; done = 1 and single tc at first held 10; further en no change.
- Mode BOUNCE, start 1, step 4, limit 13 -> 1,5,9,13,13(dir 1,tc),9,5,1,1(dir 0,tc),5.
- en toggling plus cfg_load asserted together with en at a terminal cycle -> load wins, count = cfg_start, tc 0; step 0 -> count constant, tc never high.
- Async reset asserted mid-sequence between clock edges -> count 0, dir 0, done 0, tc 0 immediately; config back to defaults.
